// File: rtl/delay_arb_pkg.sv
// Shared types and helpers for the delay timer arbiter.
package delay_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } arb_state_e;

  localparam int unsigned DEF_NUM_REQ   = 4;
  localparam int unsigned DEF_CNT_WIDTH = 8;

  // Index of the set bit in a one-hot vector (highest set bit if not one-hot).
  function automatic int unsigned onehot_to_idx(input logic [31:0] v);
    onehot_to_idx = 0;
    for (int unsigned k = 0; k < 32; k++) begin
      if (v[k]) onehot_to_idx = k;
    end
  endfunction

endpackage

// File: rtl/delay_arb_rr_picker.sv
// Combinational round-robin selector: first set request at or after the
// pointer, wrapping past the top requester.
module delay_arb_rr_picker
  import delay_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = DEF_NUM_REQ,
  localparam int unsigned PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [PTR_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_winner,
  output logic               o_valid
);

  // Scan requesters starting at the pointer; the first hit wins.
  always_comb begin
    int unsigned idx;
    idx      = 0;
    o_winner = '0;
    o_valid  = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = 32'(i_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!o_valid && i_req[PTR_W'(idx)]) begin
        o_winner[PTR_W'(idx)] = 1'b1;
        o_valid               = 1'b1;
      end
    end
  end

endmodule

// File: rtl/delay_timer_arbiter.sv
// Shared programmable delay counter with round-robin ownership.
// Optional build macro: DELAY_ARB_ABORT_EN (owner dropping req mid-run aborts).
module delay_timer_arbiter
  import delay_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ   = DEF_NUM_REQ,
  parameter int unsigned CNT_WIDTH = DEF_CNT_WIDTH
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           enable,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*CNT_WIDTH-1:0]   delay,
  output logic [NUM_REQ-1:0]             grant,
  output logic [NUM_REQ-1:0]             done,
  output logic                           busy,
  output logic [CNT_WIDTH-1:0]           count
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_e             r_state, w_state_nxt;
  logic [NUM_REQ-1:0]     r_grant, w_grant_nxt;
  logic [NUM_REQ-1:0]     r_done,  w_done_nxt;
  logic                   r_busy;
  logic [CNT_WIDTH-1:0]   r_count, w_count_nxt;
  logic [CNT_WIDTH-1:0]   r_limit, w_limit_nxt;
  logic [PTR_W-1:0]       r_ptr,   w_ptr_nxt;

  logic [NUM_REQ-1:0]     w_winner;
  logic                   w_valid;
  logic [CNT_WIDTH-1:0]   w_sel_delay;
  logic [PTR_W-1:0]       w_grant_idx;
  logic [PTR_W-1:0]       w_ptr_inc;
  logic                   w_at_limit;
  logic                   w_abort;

  delay_arb_rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_picker (
    .i_req    (req),
    .i_ptr    (r_ptr),
    .o_winner (w_winner),
    .o_valid  (w_valid)
  );

  assign w_grant_idx = PTR_W'(onehot_to_idx(32'(r_grant)));
  assign w_ptr_inc   = (w_grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : w_grant_idx + 1'b1;
  assign w_at_limit  = (r_count == r_limit);

`ifdef DELAY_ARB_ABORT_EN
  assign w_abort = (r_state == RUN) && ((req & r_grant) == '0);
`else
  assign w_abort = 1'b0;
`endif

  // Mux the winner's delay field; only meaningful when w_valid.
  always_comb begin
    w_sel_delay = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (w_winner[k]) w_sel_delay = delay[k*CNT_WIDTH +: CNT_WIDTH];
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state logic; abort outranks reaching the limit.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_valid) w_state_nxt = RUN;
      RUN: begin
        if (w_abort)                    w_state_nxt = IDLE;
        else if (enable && w_at_limit)  w_state_nxt = DONE;
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Next values of the registered outputs and datapath.
  always_comb begin
    w_grant_nxt = r_grant;
    w_done_nxt  = '0;
    w_count_nxt = r_count;
    w_limit_nxt = r_limit;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      IDLE: begin
        if (w_valid) begin
          w_grant_nxt = w_winner;
          w_limit_nxt = w_sel_delay;
          w_count_nxt = '0;
        end
      end
      RUN: begin
        if (w_abort) begin
          w_grant_nxt = '0;
          w_count_nxt = '0;
          w_ptr_nxt   = w_ptr_inc;
        end else if (enable) begin
          if (w_at_limit) w_done_nxt  = r_grant;
          else            w_count_nxt = r_count + 1'b1;
        end
      end
      DONE: begin
        w_grant_nxt = '0;
        w_count_nxt = '0;
        w_ptr_nxt   = w_ptr_inc;
      end
      default: begin
        w_grant_nxt = '0;
        w_count_nxt = '0;
      end
    endcase
  end

  // Output and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_grant <= '0;
      r_done  <= '0;
      r_busy  <= 1'b0;
      r_count <= '0;
      r_limit <= '0;
      r_ptr   <= '0;
    end else begin
      r_grant <= w_grant_nxt;
      r_done  <= w_done_nxt;
      r_busy  <= (w_state_nxt != IDLE);
      r_count <= w_count_nxt;
      r_limit <= w_limit_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  assign grant = r_grant;
  assign done  = r_done;
  assign busy  = r_busy;
  assign count = r_count;

endmodule
